// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the memory-stage data responder.
// Holds the responder state encoding and the data word width.
package dmem_pkg;
   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_t;
endpackage

// File: rtl/dmem_resp_if.sv
// dmem_resp_if: memory-stage control bus between the pipeline and
// the data responder.
// master = pipeline side (drives requests),
// slave  = responder side (returns data/stall).
interface dmem_resp_if;
   import dmem_pkg::*;

   logic              MemWriteM;
   logic              MemtoRegM;
   logic [WORD_W-1:0] ALUOutM;
   logic [WORD_W-1:0] WriteDataM;
   logic [WORD_W-1:0] ReadDataM;
   logic              StallM;
   logic              ReadValidM;

   modport master (
      output MemWriteM,
      output MemtoRegM,
      output ALUOutM,
      output WriteDataM,
      input  ReadDataM,
      input  StallM,
      input  ReadValidM
   );

   modport slave (
      input  MemWriteM,
      input  MemtoRegM,
      input  ALUOutM,
      input  WriteDataM,
      output ReadDataM,
      output StallM,
      output ReadValidM
   );
endinterface

// File: rtl/dmem_array.sv
// dmem_array: DEPTH_WORDS x 32 word storage, no reset.
// Ports: clk, writeEn/writeIdx/writeData (sync write),
// readIdx/readData (async read).
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64
) (
   input  logic                           clk,
   input  logic                           writeEn,
   input  logic [$clog2(DEPTH_WORDS)-1:0] writeIdx,
   input  logic [WORD_W-1:0]              writeData,
   input  logic [$clog2(DEPTH_WORDS)-1:0] readIdx,
   output logic [WORD_W-1:0]              readData
);
   logic [WORD_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (writeEn) begin
         mem[writeIdx] <= writeData;
      end
   end

   assign readData = mem[readIdx];
endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: multi-cycle data-memory responder for the memory stage.
// Ports: clk, reset (sync, active-low), bus (dmem_resp_if.slave).
module dmem_resp
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   dmem_resp_if.slave  bus
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t            state;
   state_t            stateNext;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  countNext;

   logic [IDX_W-1:0]  idxQ;
   logic [WORD_W-1:0] dataQ;
   logic              storeQ;

   logic [WORD_W-1:0] readData;
   logic              readValid;

   logic              req;
   logic [IDX_W-1:0]  reqIdx;
   logic              accept;
   logic              finish;
   logic              stall;
   logic [IDX_W-1:0]  accIdx;
   logic [WORD_W-1:0] accData;
   logic              accStore;
   logic [WORD_W-1:0] arrRead;
   logic              arrWrite;
   logic              unusedAddrBits;

   assign req    = bus.MemWriteM | bus.MemtoRegM;
   assign reqIdx = bus.ALUOutM[IDX_W+1:2];

   assign unusedAddrBits = ^{bus.ALUOutM[WORD_W-1:IDX_W+2],
                             bus.ALUOutM[1:0]};

   // finish marks the edge that enters DONE. With LATENCY==1 that is
   // the accepting edge itself, so the live request is steered to the
   // array instead of the (not yet loaded) latch.
   always_comb begin
      stateNext = state;
      countNext = count;
      accept    = 1'b0;
      finish    = 1'b0;
      stall     = 1'b0;
      accIdx    = idxQ;
      accData   = dataQ;
      accStore  = storeQ;
      unique case (state)
         IDLE: begin
            if (req) begin
               accept    = 1'b1;
               stall     = 1'b1;
               countNext = CNT_LOAD;
               accIdx    = reqIdx;
               accData   = bus.WriteDataM;
               accStore  = bus.MemWriteM;
               if (LATENCY > 1) begin
                  stateNext = WAIT;
               end else begin
                  stateNext = DONE;
                  finish    = 1'b1;
               end
            end
         end
         WAIT: begin
            stall     = 1'b1;
            countNext = count - CNT_ONE;
            // Leave WAIT on the edge where the count reaches zero.
            if (count <= CNT_ONE) begin
               stateNext = DONE;
               finish    = 1'b1;
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Reset dominates: no write, no stall, no accept while asserted.
   assign arrWrite = reset & finish & accStore;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         count     <= '0;
         readData  <= '0;
         readValid <= 1'b0;
      end else begin
         state     <= stateNext;
         count     <= countNext;
         readValid <= finish & ~accStore;
         if (finish && !accStore) begin
            readData <= arrRead;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset && accept) begin
         idxQ   <= reqIdx;
         dataQ  <= bus.WriteDataM;
         storeQ <= bus.MemWriteM;
      end
   end

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) uArray (
      .clk       (clk),
      .writeEn   (arrWrite),
      .writeIdx  (accIdx),
      .writeData (accData),
      .readIdx   (accIdx),
      .readData  (arrRead)
   );

   assign bus.StallM     = stall & reset;
   assign bus.ReadDataM  = readData;
   assign bus.ReadValidM = readValid;
endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: randomized self-checking bench for dmem_resp.
// Two instances: LATENCY=2 (A) and LATENCY=1 (B), DEPTH_WORDS=64.
module tb_dmem_resp;
   logic clk = 1'b0;
   logic reset = 1'b0;

   dmem_resp_if busA ();
   dmem_resp_if busB ();

   dmem_resp #(.DEPTH_WORDS(64), .LATENCY(2)) dutA (
      .clk   (clk),
      .reset (reset),
      .bus   (busA)
   );

   dmem_resp #(.DEPTH_WORDS(64), .LATENCY(1)) dutB (
      .clk   (clk),
      .reset (reset),
      .bus   (busB)
   );

   always #5 clk = ~clk;

   int nTests = 0;
   int nFail  = 0;

   logic [31:0] memA [64];
   logic [31:0] memB [64];
   logic [31:0] lastA;
   logic [31:0] lastB;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] want);
      nTests++;
      if (got !== want) begin
         nFail++;
         $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic drive(input bit b, input bit w, input bit r,
                        input logic [31:0] a, input logic [31:0] d);
      if (b) begin
         busB.MemWriteM  = w;
         busB.MemtoRegM  = r;
         busB.ALUOutM    = a;
         busB.WriteDataM = d;
      end else begin
         busA.MemWriteM  = w;
         busA.MemtoRegM  = r;
         busA.ALUOutM    = a;
         busA.WriteDataM = d;
      end
   endtask

   task automatic sample(input bit b, output logic st, output logic rv,
                         output logic [31:0] rd);
      if (b) begin
         st = busB.StallM;
         rv = busB.ReadValidM;
         rd = busB.ReadDataM;
      end else begin
         st = busA.StallM;
         rv = busA.ReadValidM;
         rd = busA.ReadDataM;
      end
   endtask

   // One complete access; called just after a rising edge.
   // Inputs carry random junk during stall and DONE cycles.
   task automatic access(input bit b, input bit w, input bit r,
                         input logic [31:0] a, input logic [31:0] d);
      int lat = b ? 1 : 2;
      int idx = int'((a / 4) % 64);
      bit isLd = r & ~w;
      logic st, rv;
      logic [31:0] rd, want;
      drive(b, w, r, a, d);
      for (int k = 0; k < lat; k++) begin
         @(negedge clk);
         sample(b, st, rv, rd);
         check("stallBusy", 32'(st), 32'd1);
         check("rvBusy", 32'(rv), 32'd0);
         @(posedge clk);
         #1;
         drive(b, 1'($urandom), 1'($urandom), $urandom, $urandom);
      end
      @(negedge clk);
      sample(b, st, rv, rd);
      check("stallDone", 32'(st), 32'd0);
      if (isLd) begin
         want = b ? memB[idx] : memA[idx];
         if (b) lastB = want;
         else lastA = want;
         check("rvLoad", 32'(rv), 32'd1);
         if (!$isunknown(want)) check("loadData", rd, want);
      end else begin
         want = b ? lastB : lastA;
         check("rvStore", 32'(rv), 32'd0);
         if (!$isunknown(want)) check("holdStore", rd, want);
         if (b) memB[idx] = d;
         else memA[idx] = d;
      end
      @(posedge clk);
      #1;
      drive(b, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic idle(input int n);
      logic st, rv;
      logic [31:0] rd;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sample(1'b0, st, rv, rd);
         check("stallIdle", 32'(st), 32'd0);
         check("rvIdle", 32'(rv), 32'd0);
         if (!$isunknown(lastA)) check("holdIdle", rd, lastA);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic st, rv;
      logic [31:0] rd;
      for (int i = 0; i < 64; i++) begin
         memA[i] = 'x;
         memB[i] = 'x;
      end
      lastA = 32'd0;
      lastB = 32'd0;
      drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1'b0, 1'b0, 1'b1, 32'h10, 32'd0);

      // Reset held two cycles with a load request present.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         sample(1'b0, st, rv, rd);
         check("stallRst", 32'(st), 32'd0);
         check("rvRst", 32'(rv), 32'd0);
         check("rdRst", rd, 32'd0);
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      access(1'b0, 1'b0, 1'b1, 32'h10, 32'd0);

      // Store then load.
      access(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
      access(1'b0, 1'b0, 1'b1, 32'h10, 32'd0);
      idle(1);

      // Wrap and alignment.
      access(1'b0, 1'b1, 1'b0, 32'h104, 32'h12345678);
      access(1'b0, 1'b0, 1'b1, 32'h004, 32'd0);
      access(1'b0, 1'b0, 1'b1, 32'h007, 32'd0);

      // Both request bits: store wins.
      access(1'b0, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);
      access(1'b0, 1'b0, 1'b1, 32'h20, 32'd0);

      // Reset in the middle of a store.
      access(1'b0, 1'b1, 1'b0, 32'h30, 32'h00002222);
      drive(1'b0, 1'b1, 1'b0, 32'h30, 32'h00001111);
      @(negedge clk);
      sample(1'b0, st, rv, rd);
      check("stallMid", 32'(st), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      lastA = 32'd0;
      @(negedge clk);
      sample(1'b0, st, rv, rd);
      check("stallAfterRst", 32'(st), 32'd0);
      check("rvAfterRst", 32'(rv), 32'd0);
      check("rdAfterRst", rd, 32'd0);
      @(posedge clk);
      #1;
      access(1'b0, 1'b0, 1'b1, 32'h30, 32'd0);

      // Random traffic with wrapping addresses and idle gaps.
      for (int n = 0; n < 150; n++) begin
         int kind = int'($urandom_range(0, 2));
         logic [31:0] a = 32'($urandom_range(0, 1023));
         logic [31:0] d = $urandom;
         access(1'b0, kind != 1, kind != 0, a, d);
         idle(int'($urandom_range(0, 2)));
      end

      // LATENCY=1 instance: back-to-back loads.
      access(1'b1, 1'b1, 1'b0, 32'h0, 32'h0BADF00D);
      access(1'b1, 1'b1, 1'b0, 32'h4, $urandom);
      access(1'b1, 1'b0, 1'b1, 32'h0, 32'd0);
      access(1'b1, 1'b0, 1'b1, 32'h4, 32'd0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule
